// File: rtl/logic_map_pkg.sv
// Shared types and helpers for the logic-region aging-sensor scan engine.
package logic_map_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT
    } state_e;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 24;

    typedef struct packed {
        logic [4:0]            region;
        logic [ADDR_W_DEF-1:0] osc;
        logic [DATA_W_DEF-1:0] data;
    } rec_t;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/logic_map_settle_cnt.sv
// Loadable down-counter timing the settle window after an address change.
module logic_map_settle_cnt #(
    parameter int CYC = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/logic_map_scanner.sv
// Autonomous readout sequencer for the aging-sensor regions.
// Optional threshold flag/alarm enabled by defining LOGIC_MAP_THRESH_EN.
module logic_map_scanner
    import logic_map_pkg::*;
#(
    parameter int NUM_REGION = 17,
    parameter int NUM_OSC    = 10,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETTLE_CYC = 64,
    localparam int RW = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start_i,
    input  logic                         continuous_i,
    input  logic                         abort_i,
    output logic [NUM_REGION*ADDR_W-1:0] RAddr_o,
    input  logic [NUM_REGION*DATA_W-1:0] RData_i,
    output logic                         rec_valid_o,
    input  logic                         rec_ready_i,
    output logic [RW-1:0]                rec_region_o,
    output logic [ADDR_W-1:0]            rec_osc_o,
    output logic [DATA_W-1:0]            rec_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [15:0]                  scan_cnt_o,
    input  logic [DATA_W-1:0]            thresh_i,
    output logic                         rec_flag_o,
    output logic                         alarm_o
);

    localparam logic [RW-1:0]     REG_LAST = RW'(NUM_REGION - 1);
    localparam logic [ADDR_W-1:0] OSC_LAST = ADDR_W'(NUM_OSC - 1);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] osc_q, osc_d;
    logic [RW-1:0]     reg_q, reg_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [RW-1:0]     region_q, region_d;
    logic [ADDR_W-1:0] rosc_q, rosc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       scan_q, scan_d;
    logic              done_q, done_d;

    logic              start_ok, accept, capture;
    logic              last_reg, last_osc, resettle;
    logic              settle_load, settle_done;
    logic [DATA_W-1:0] rdata_sel;

    assign start_ok  = (state_q == S_IDLE) && start_i && !abort_i;
    assign accept    = (state_q == S_EMIT) && rec_ready_i && !abort_i;
    assign capture   = (state_q == S_CAPTURE) && !abort_i;
    assign last_reg  = (reg_q == REG_LAST);
    assign last_osc  = (osc_q == OSC_LAST);
    assign resettle  = !last_osc || continuous_i;
    assign rdata_sel = RData_i[slice_lo(int'(reg_q), DATA_W) +: DATA_W];

    assign settle_load = start_ok || (accept && last_reg && resettle);

    logic_map_settle_cnt #(
        .CYC(SETTLE_CYC)
    ) u_settle (
        .clk      (clk),
        .rstn     (rstn),
        .load_i   (settle_load),
        .en_i     (state_q == S_SETTLE),
        .expired_o(settle_done)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_i) state_d = S_SETTLE;
                S_SETTLE:  if (settle_done) state_d = S_CAPTURE;
                S_CAPTURE: state_d = S_EMIT;
                S_EMIT: begin
                    if (rec_ready_i) begin
                        if (!last_reg) begin
                            state_d = S_CAPTURE;
                        end else if (resettle) begin
                            state_d = S_SETTLE;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Abort withdraws valid in the same cycle so no handshake can slip through.
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        rec_valid_o = (state_q == S_EMIT) && !abort_i;
    end

    always_comb begin
        osc_d    = osc_q;
        reg_d    = reg_q;
        raddr_d  = raddr_q;
        region_d = region_q;
        rosc_d   = rosc_q;
        data_d   = data_q;
        scan_d   = scan_q;
        done_d   = 1'b0;
        if (start_ok) begin
            osc_d   = '0;
            reg_d   = '0;
            raddr_d = '0;
        end
        if (capture) begin
            region_d = reg_q;
            rosc_d   = osc_q;
            data_d   = rdata_sel;
        end
        if (accept) begin
            if (!last_reg) begin
                reg_d = reg_q + RW'(1);
            end else begin
                reg_d = '0;
                if (!last_osc) begin
                    osc_d   = osc_q + ADDR_W'(1);
                    raddr_d = osc_q + ADDR_W'(1);
                end else begin
                    osc_d  = '0;
                    done_d = 1'b1;
                    scan_d = scan_q + 16'd1;
                    if (continuous_i) raddr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            osc_q    <= '0;
            reg_q    <= '0;
            raddr_q  <= '0;
            region_q <= '0;
            rosc_q   <= '0;
            data_q   <= '0;
            scan_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            osc_q    <= osc_d;
            reg_q    <= reg_d;
            raddr_q  <= raddr_d;
            region_q <= region_d;
            rosc_q   <= rosc_d;
            data_q   <= data_d;
            scan_q   <= scan_d;
            done_q   <= done_d;
        end
    end

    for (genvar g = 0; g < NUM_REGION; g++) begin : g_raddr
        assign RAddr_o[slice_lo(g, ADDR_W) +: ADDR_W] = raddr_q;
    end

    assign rec_region_o = region_q;
    assign rec_osc_o    = rosc_q;
    assign rec_data_o   = data_q;
    assign scan_cnt_o   = scan_q;
    assign done_o       = done_q;

`ifdef LOGIC_MAP_THRESH_EN
    logic flag_q, flag_d;
    logic alarm_q, alarm_d;

    always_comb begin
        flag_d  = flag_q;
        alarm_d = alarm_q;
        if (capture) flag_d = (rdata_sel < thresh_i);
        if (start_ok) begin
            alarm_d = 1'b0;
        end else if (accept && flag_q) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            flag_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            alarm_q <= alarm_d;
        end
    end

    assign rec_flag_o = flag_q;
    assign alarm_o    = alarm_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh_i;
    assign rec_flag_o    = 1'b0;
    assign alarm_o       = 1'b0;
`endif

endmodule

// File: tb/tb_logic_map_scanner.sv
// Scoreboard bench for logic_map_scanner on a 3-region, 2-oscillator array.
module tb_logic_map_scanner;

    localparam int NR = 3;
    localparam int NO = 2;
    localparam int AW = 5;
    localparam int DW = 24;
    localparam int SC = 4;
    localparam int RW = 2;
`ifdef LOGIC_MAP_THRESH_EN
    localparam bit TH = 1'b1;
`else
    localparam bit TH = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_i = 1'b0;
    logic continuous_i = 1'b0;
    logic abort_i = 1'b0;
    logic rec_ready_i = 1'b0;
    logic [DW-1:0] thresh_i = 24'h150;
    logic [NR*AW-1:0] RAddr_o;
    logic [NR*DW-1:0] RData_i;
    logic rec_valid_o, busy_o, done_o, rec_flag_o, alarm_o;
    logic [RW-1:0] rec_region_o;
    logic [AW-1:0] rec_osc_o;
    logic [DW-1:0] rec_data_o;
    logic [15:0] scan_cnt_o;

    typedef struct {
        int r;
        int o;
        int d;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int rec_cnt = 0;
    int done_cnt = 0;
    int exp_scans = 0;

    logic_map_scanner #(
        .NUM_REGION(NR),
        .NUM_OSC   (NO),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SETTLE_CYC(SC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .continuous_i(continuous_i),
        .abort_i     (abort_i),
        .RAddr_o     (RAddr_o),
        .RData_i     (RData_i),
        .rec_valid_o (rec_valid_o),
        .rec_ready_i (rec_ready_i),
        .rec_region_o(rec_region_o),
        .rec_osc_o   (rec_osc_o),
        .rec_data_o  (rec_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .scan_cnt_o  (scan_cnt_o),
        .thresh_i    (thresh_i),
        .rec_flag_o  (rec_flag_o),
        .alarm_o     (alarm_o)
    );

    always #5 clk = ~clk;

    // Sensor model: each region reports 0x100*region + its current address.
    always_comb begin
        RData_i = '0;
        for (int r = 0; r < NR; r++) begin
            RData_i[r*DW +: DW] = DW'(32'h100 * r) + DW'(RAddr_o[r*AW +: AW]);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        logic ef;
        if (done_o) done_cnt++;
        if (rstn && rec_valid_o && rec_ready_i) begin
            checks++;
            rec_cnt++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rec_extra got r%0d o%0d d%h, expected none",
                         rec_region_o, rec_osc_o, rec_data_o);
            end else begin
                e = q.pop_front();
                ef = TH && (e.d < 32'h150);
                if (rec_region_o !== RW'(e.r) || rec_osc_o !== AW'(e.o) ||
                    rec_data_o !== DW'(e.d) || rec_flag_o !== ef) begin
                    errors++;
                    $display("FAIL rec got r%0d o%0d d%h f%b, expected r%0d o%0d d%h f%b",
                             rec_region_o, rec_osc_o, rec_data_o, rec_flag_o,
                             e.r, e.o, e.d, ef);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan();
        for (int o = 0; o < NO; o++) begin
            for (int r = 0; r < NR; r++) begin
                q.push_back('{r, o, 32'h100 * r + o});
            end
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_o || q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got busy=%b pending=%0d, expected 0/0",
                     name, busy_o, q.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy_o !== 1'b0 || rec_valid_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b, expected 000", busy_o, rec_valid_o, done_o);
        end
        checks++;
        if (RAddr_o !== '0 || scan_cnt_o !== 16'h0 || alarm_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs got addr=%h cnt=%h alarm=%b, expected 0",
                     RAddr_o, scan_cnt_o, alarm_o);
        end
    endtask

    task automatic test_basic();
        int n;
        int d0;
        logic [NR*AW-1:0] last_addr;
        last_addr = {NR{AW'(NO - 1)}};
        d0 = done_cnt;
        rec_ready_i = 1'b1;
        push_scan();
        pulse_start();
        n = 1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b, expected 1", busy_o);
        end
        while (!rec_valid_o && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n != SC + 2) begin
            errors++;
            $display("FAIL first_valid_latency got %0d, expected %0d", n, SC + 2);
        end
        tick();
        checks++;
        if (rec_valid_o !== 1'b0 || alarm_o !== TH) begin
            errors++;
            $display("FAIL gap_after_accept got valid=%b alarm=%b, expected 0/%b",
                     rec_valid_o, alarm_o, TH);
        end
        tick();
        checks++;
        if (rec_valid_o !== 1'b1 || rec_region_o !== RW'(1)) begin
            errors++;
            $display("FAIL region_spacing got valid=%b r=%0d, expected 1/1",
                     rec_valid_o, rec_region_o);
        end
        wait_idle("basic");
        exp_scans++;
        checks++;
        if (done_cnt - d0 != 1 || scan_cnt_o !== 16'(exp_scans)) begin
            errors++;
            $display("FAIL basic_done got pulses=%0d cnt=%0d, expected 1/%0d",
                     done_cnt - d0, scan_cnt_o, exp_scans);
        end
        checks++;
        if (RAddr_o !== last_addr) begin
            errors++;
            $display("FAIL idle_addr_hold got %h, expected %h", RAddr_o, last_addr);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        int base;
        base = rec_cnt;
        rec_ready_i = 1'b1;
        push_scan();
        pulse_start();
        while (rec_cnt == base && n < 50) begin
            tick();
            n++;
        end
        rec_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (rec_valid_o !== 1'b1 || rec_region_o !== RW'(1) ||
                rec_osc_o !== AW'(0) || rec_data_o !== DW'(32'h100)) begin
                errors++;
                $display("FAIL stall_hold got v=%b r%0d o%0d d%h, expected 1 r1 o0 d000100",
                         rec_valid_o, rec_region_o, rec_osc_o, rec_data_o);
            end
        end
        rec_ready_i = 1'b1;
        wait_idle("backpressure");
        exp_scans++;
        checks++;
        if (rec_cnt - base != NR * NO || scan_cnt_o !== 16'(exp_scans)) begin
            errors++;
            $display("FAIL stall_count got recs=%0d cnt=%0d, expected %0d/%0d",
                     rec_cnt - base, scan_cnt_o, NR * NO, exp_scans);
        end
    endtask

    task automatic test_continuous();
        int nd = 0;
        int n = 0;
        int d0;
        d0 = done_cnt;
        continuous_i = 1'b1;
        rec_ready_i = 1'b1;
        for (int s = 0; s < 3; s++) push_scan();
        pulse_start();
        while (nd < 2 && n < 500) begin
            tick();
            n++;
            if (done_o) begin
                nd++;
                checks++;
                if (RAddr_o !== '0 || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_addr got addr=%h busy=%b, expected 0/1",
                             RAddr_o, busy_o);
                end
            end
        end
        continuous_i = 1'b0;
        checks++;
        if (nd != 2) begin
            errors++;
            $display("FAIL cont_timeout got %0d scans, expected 2", nd);
        end
        wait_idle("continuous");
        exp_scans += 3;
        checks++;
        if (done_cnt - d0 != 3 || scan_cnt_o !== 16'(exp_scans)) begin
            errors++;
            $display("FAIL cont_count got pulses=%0d cnt=%0d, expected 3/%0d",
                     done_cnt - d0, scan_cnt_o, exp_scans);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int base;
        int d0;
        base = rec_cnt;
        d0 = done_cnt;
        rec_ready_i = 1'b1;
        push_scan();
        pulse_start();
        while (rec_cnt - base < 3 && n < 100) begin
            tick();
            n++;
        end
        while (!rec_valid_o && n < 100) begin
            tick();
            n++;
        end
        abort_i = 1'b1;
        #1;
        checks++;
        if (rec_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid_drop got %b, expected 0", rec_valid_o);
        end
        tick();
        abort_i = 1'b0;
        checks++;
        if (rec_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got valid=%b busy=%b, expected 0/0",
                     rec_valid_o, busy_o);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (done_cnt != d0 || scan_cnt_o !== 16'(exp_scans) || q.size() != 3) begin
            errors++;
            $display("FAIL abort_side got pulses=%0d cnt=%0d pending=%0d, expected 0/%0d/3",
                     done_cnt - d0, scan_cnt_o, q.size(), exp_scans);
        end
        q.delete();
        push_scan();
        pulse_start();
        wait_idle("rescan");
        exp_scans++;
        checks++;
        if (scan_cnt_o !== 16'(exp_scans)) begin
            errors++;
            $display("FAIL rescan_count got %0d, expected %0d", scan_cnt_o, exp_scans);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        rec_ready_i = 1'b1;
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_start got busy=%b, expected 0", busy_o);
        end
        push_scan();
        pulse_start();
        checks++;
        if (alarm_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_alarm got alarm=%b busy=%b, expected 0/1",
                     alarm_o, busy_o);
        end
        tick();
        tick();
        pulse_start();
        wait_idle("busy_start");
        exp_scans++;
        checks++;
        if (done_cnt - d0 != 1 || scan_cnt_o !== 16'(exp_scans)) begin
            errors++;
            $display("FAIL start_while_busy got pulses=%0d cnt=%0d, expected 1/%0d",
                     done_cnt - d0, scan_cnt_o, exp_scans);
        end
    endtask

    task automatic test_reset_mid();
        rec_ready_i = 1'b1;
        push_scan();
        pulse_start();
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (busy_o !== 1'b1 || RAddr_o === '0) begin
            errors++;
            $display("FAIL mid_scan_state got busy=%b addr=%h, expected 1/nonzero",
                     busy_o, RAddr_o);
        end
        rstn = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || rec_valid_o !== 1'b0 || RAddr_o !== '0 ||
            scan_cnt_o !== 16'h0 || rec_data_o !== '0 || alarm_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b v=%b addr=%h cnt=%h d=%h alarm=%b, expected 0",
                     busy_o, rec_valid_o, RAddr_o, scan_cnt_o, rec_data_o, alarm_o);
        end
        rstn = 1'b1;
        q.delete();
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        tick();
        tick();
        tick();
        test_reset();
        rstn = 1'b1;
        tick();
        test_basic();
        test_backpressure();
        test_continuous();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
